spi_slave_fsm: RTL and testbench

//  SPI slave front-end that sits directly upstream of the single-port RAM in the SPI wrapper.
//  - Deserialises MOSI into 10-bit frames {cmd[1:0], payload[7:0]} and presents each frame to the RAM on rx_data/rx_valid.
//  - On read-data frames, captures the RAM's tx_data on tx_valid and serialises it MSB-first on MISO.

---
 rtl/spi_slave_fsm_if.sv | 25 ++
 rtl/spi_slave_fsm.sv | 135 +++++++++++++
 tb/tb_spi_slave_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fsm_if.sv
// SPI slave bus: serial pins plus the RAM-facing frame/read-data handshake.
// The slave modport faces the design, the master modport faces its driver.
interface spi_slave_fsm_if #(
  parameter int FRAME_W = 10,
  parameter int TX_W    = 8
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [TX_W-1:0]    tx_data;
  logic               tx_valid;
  logic               frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave front-end: deserialises 10-bit MOSI frames for the RAM and
// returns read data MSB-first on MISO. Optional: SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_fsm #(
  parameter int FRAME_W = 10,
  parameter int TX_W    = 8
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // r_cnt: 0..FRAME_W counts received bits, then FRAME_W+n after n MISO bits
  localparam logic [4:0] RX_DONE = 5'(FRAME_W);
  localparam logic [4:0] TX_LAST = 5'(FRAME_W + TX_W);
  localparam logic [4:0] TX_END  = 5'(FRAME_W + TX_W + 1);

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic [TX_W-1:0]    r_tx_sh;
  logic               r_miso;
  logic               r_rd_ok;

  logic w_mid;
  logic w_rd;
  logic w_abort;

  // mid-frame: receiving, or read data not yet fully shifted out
  assign w_rd    = (r_state == READ_DATA);
  assign w_mid   = (r_state != IDLE) &&
                   ((r_cnt < RX_DONE) || (w_rd && r_cnt < TX_LAST));
  assign w_abort = bus.SS_n && w_mid;

  // frame FSM with registered frame, strobe and MISO outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_sh    <= '0;
      r_miso     <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_cnt  <= '0;
            r_miso <= 1'b0;
            if (!bus.SS_n)
              r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            r_rx_data <= {r_rx_data[FRAME_W-2:0], bus.MOSI};
            r_cnt     <= 5'd1;
            if (!bus.MOSI)
              r_state <= WRITE;
            else if (r_rd_ok)
              r_state <= READ_DATA;
            else
              r_state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (r_cnt < RX_DONE) begin
              r_rx_data <= {r_rx_data[FRAME_W-2:0], bus.MOSI};
              r_cnt     <= r_cnt + 5'd1;
              if (r_cnt == RX_DONE - 5'd1) begin
                r_rx_valid <= 1'b1;
                if (r_state == READ_ADD)
                  r_rd_ok <= 1'b1;
              end
            end else if (w_rd && r_cnt == RX_DONE) begin
              if (bus.tx_valid) begin
                r_miso  <= bus.tx_data[TX_W-1];
                r_tx_sh <= {bus.tx_data[TX_W-2:0], 1'b0};
                r_cnt   <= r_cnt + 5'd1;
              end
            end else if (w_rd && r_cnt < TX_LAST) begin
              r_miso  <= r_tx_sh[TX_W-1];
              r_tx_sh <= {r_tx_sh[TX_W-2:0], 1'b0};
              r_cnt   <= r_cnt + 5'd1;
            end else if (w_rd && r_cnt == TX_LAST) begin
              r_miso  <= 1'b0;
              r_rd_ok <= 1'b0;
              r_cnt   <= TX_END;
              if (bus.SS_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end
            end else if (bus.SS_n) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.MISO     = r_miso;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_frame_err;

  // one-cycle pulse whenever SS_n rises before the frame completed
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_frame_err <= 1'b0;
    else
      r_frame_err <= w_abort;
  end

  assign bus.frame_err = r_frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: directed SPI transactions then random frames,
// checked against a frame-level model of the read-address flag.
module tb_spi_slave_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   m_rd_ok = 1'b0;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  spi_slave_fsm_if bus ();

  spi_slave_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SS_n raised (or reset asserted) in the middle of a frame
  task automatic stop_frame(input bit use_rst);
    bus.tx_valid = 1'b0;
    bus.SS_n     = 1'b1;
    if (use_rst) begin
      rst_n = 1'b0;
      tick();
      chk("rst_miso", bus.MISO, 0);
      chk("rst_rxv", bus.rx_valid, 0);
      chk("rst_rxd", bus.rx_data, 0);
      chk("rst_ferr", bus.frame_err, 0);
      m_rd_ok = 1'b0;
      rst_n = 1'b1;
      tick();
    end else begin
      tick();
      chk("abort_rxv", bus.rx_valid, 0);
      chk("abort_miso", bus.MISO, 0);
      chk("abort_ferr", bus.frame_err, 32'(FE));
      tick();
      chk("ferr_once", bus.frame_err, 0);
    end
  endtask

  // ab: -1 none; 0..9 stop after that many bits; 10+k stop after k MISO bits
  task automatic frame(input logic [9:0] f, input logic [7:0] d,
                       input int ab, input bit use_rst, input int extra);
    bit is_rd;
    is_rd = f[9] && m_rd_ok;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (ab == i) begin
        stop_frame(use_rst);
        return;
      end
      bus.MOSI = f[9-i];
      tick();
      if (i == 8)
        chk("rxv_early", bus.rx_valid, 0);
    end
    chk("rxv", bus.rx_valid, 1);
    chk("rx_data", bus.rx_data, 32'(f));
    if (f[9] && !m_rd_ok)
      m_rd_ok = 1'b1;
    if (is_rd) begin
      bus.MOSI = 1'($urandom);
      tick();
      chk("rxv_one", bus.rx_valid, 0);
      chk("miso_wait", bus.MISO, 0);
      if (ab == 10) begin
        stop_frame(use_rst);
        return;
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      tick();
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      chk("miso_b7", bus.MISO, 32'(d[7]));
      for (int k = 1; k < 8; k++) begin
        if (ab == 10 + k) begin
          stop_frame(use_rst);
          return;
        end
        tick();
        chk("miso_bit", bus.MISO, 32'(d[7-k]));
      end
      tick();
      chk("miso_done", bus.MISO, 0);
      m_rd_ok = 1'b0;
    end else begin
      for (int e = 0; e < extra; e++) begin
        bus.MOSI     = 1'($urandom);
        bus.tx_valid = 1'($urandom);
        bus.tx_data  = 8'($urandom);
        tick();
        chk("extra_rxv", bus.rx_valid, 0);
        chk("extra_rxd", bus.rx_data, 32'(f));
        chk("extra_miso", bus.MISO, 0);
      end
      bus.tx_valid = 1'b0;
    end
    bus.SS_n = 1'b1;
    tick();
    chk("end_miso", bus.MISO, 0);
    chk("end_ferr", bus.frame_err, 0);
  endtask

  initial begin
    logic [9:0] f;
    logic [7:0] d;
    int         ab;
    int         r;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    tick();
    tick();
    chk("reset_miso", bus.MISO, 0);
    chk("reset_rxv", bus.rx_valid, 0);
    chk("reset_rxd", bus.rx_data, 0);
    chk("reset_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    tick();

    frame(10'h03A, 8'h00, -1, 1'b0, 2);
    frame(10'h23A, 8'h00, -1, 1'b0, 1);
    frame(10'h300, 8'hA5, -1, 1'b0, 0);
    frame(10'h3FF, 8'h5A, -1, 1'b0, 3);
    frame(10'h155, 8'h00, 5, 1'b0, 0);
    frame(10'h300, 8'hC3, 13, 1'b1, 0);
    frame(10'h300, 8'h96, -1, 1'b0, 2);
    frame(10'h0C7, 8'h00, -1, 1'b0, 4);
    frame(10'h300, 8'h3C, -1, 1'b0, 0);
    frame(10'h300, 8'hF0, 10, 1'b0, 0);
    frame(10'h300, 8'h81, 16, 1'b0, 0);
    frame(10'h300, 8'h81, -1, 1'b0, 0);
    frame(10'h000, 8'h00, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      f  = 10'($urandom);
      d  = 8'($urandom);
      r  = int'($urandom_range(0, 9));
      ab = -1;
      if (r == 0)
        ab = int'($urandom_range(0, 9));
      else if (r == 1)
        ab = int'($urandom_range(10, 17));
      frame(f, d, ab, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
